lcd_sequencer: RTL and testbench

- Sits between the processor control unit and the LCD display driver.
- Accepts display requests (opcode, register address, signed result value) through a valid/ready handshake and holds them in a current register plus a one-entry pending buffer.
- Drives the driver's operation select through DISPLAY_OFF, then UPDATE, then SHOW, and waits for done_show, with a timeout.
- Handles the power on/off level from the board switch.

---
 rtl/lcd_sequencer_if.sv | 35 +++
 rtl/lcd_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if
//   Request channel from the processor control unit to the LCD sequencer.
//   A request is transferred on a clk edge where req_valid && req_ready.
//
//   req_valid   : request present (control unit -> sequencer)
//   req_ready   : sequencer can take the request (sequencer -> control unit)
//   req_opcode  : opcode to display
//   req_addr    : register address
//   req_value   : sign-magnitude value, bit 15 = sign, bits 14:0 = magnitude
//
//   master : the control unit side
//   slave  : the sequencer side
interface lcd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [3:0]  req_addr;
    logic [15:0] req_value;

    modport master (
        output req_valid,
        output req_opcode,
        output req_addr,
        output req_value,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_opcode,
        input  req_addr,
        input  req_value,
        output req_ready
    );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
//   Sequences the LCD driver for each display request: the driver's
//   operation select is stepped DISPLAY_OFF -> UPDATE -> SHOW, then the
//   sequencer waits for done_show (bounded by a timeout) and holds the
//   display. Requests are held in a current register plus a one-entry
//   pending buffer so the control unit is never dropped, only back-pressured.
//
//   Parameters
//     UPDATE_CYCLES  : cycles operation is held at UPDATE (>= 3)
//     TIMEOUT_CYCLES : maximum cycles spent in SHOW before forcing completion
//
//   Ports
//     clk, rst     : clock, asynchronous active-high reset
//     power_on     : board switch level, 1 = display enabled
//     req          : request channel (slave side of lcd_sequencer_if)
//     done_show    : driver reports that the SHOW sequence finished
//     operation    : driver operation select, 0 = OFF, 1 = UPDATE, 2 = SHOW
//     opcode, addr, value : current-register fields presented to the driver
//     busy         : high while in UPDATE or SHOW
//     timeout_err  : sticky SHOW timeout flag, cleared by the next accept
module lcd_sequencer #(
    parameter int UPDATE_CYCLES  = 100000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 power_on,
    lcd_sequencer_if.slave       req,
    input  logic                 done_show,
    output logic [1:0]           operation,
    output logic [3:0]           opcode,
    output logic [3:0]           addr,
    output logic [15:0]          value,
    output logic                 busy,
    output logic                 timeout_err
);

    // The counter only has to reach the larger of the two limits minus one.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > UPDATE_CYCLES) ? TIMEOUT_CYCLES : UPDATE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] UPD_LAST = CNT_W'(UPDATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_OFF    = 2'd0;
    localparam logic [1:0] OP_UPDATE = 2'd1;
    localparam logic [1:0] OP_SHOW   = 2'd2;

    typedef enum logic [1:0] {
        S_OFF,
        S_UPDATE,
        S_SHOW,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  addr;
        logic [15:0] value;
    } entry_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    entry_t           cur, cur_n;
    entry_t           pend, pend_n;
    logic             pend_valid, pend_valid_n;
    logic             terr_n;
    logic [1:0]       op_n;
    logic             ready;
    logic             accept;
    entry_t           req_entry;

    // Handshake: OFF always takes requests straight into the current
    // register; elsewhere the only free slot is the pending buffer. In DONE
    // with a pending entry the cycle is spent promoting it, so ready is low.
    always_comb begin
        if (state == S_OFF) begin
            ready = 1'b1;
        end else begin
            ready = !pend_valid;
        end
    end

    assign req.req_ready = ready;
    assign accept        = req.req_valid && ready;
    assign req_entry     = '{opcode: req.req_opcode, addr: req.req_addr, value: req.req_value};

    assign busy   = (state == S_UPDATE) || (state == S_SHOW);
    assign opcode = cur.opcode;
    assign addr   = cur.addr;
    assign value  = cur.value;

    // Next-state and datapath update
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cur_n        = cur;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        terr_n       = timeout_err;

        if ((state != S_OFF) && !power_on) begin
            // Power switch off beats every other transition. Whatever is
            // queued becomes the current register so nothing is lost; if the
            // buffer was empty, a same-cycle accept lands there instead.
            state_n = S_OFF;
            cnt_n   = '0;
            if (pend_valid) begin
                cur_n        = pend;
                pend_valid_n = 1'b0;
            end else if (accept) begin
                cur_n = req_entry;
            end
        end else begin
            case (state)
                S_OFF: begin
                    // Accept before power-up check so a same-cycle request
                    // is the one that gets displayed.
                    if (accept) begin
                        cur_n = req_entry;
                    end
                    if (power_on) begin
                        state_n = S_UPDATE;
                        cnt_n   = '0;
                    end
                end

                S_UPDATE: begin
                    if (cnt == UPD_LAST) begin
                        state_n = S_SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                    if (accept) begin
                        pend_n       = req_entry;
                        pend_valid_n = 1'b1;
                    end
                end

                S_SHOW: begin
                    // done_show is checked first: a completion on the same
                    // cycle as the timeout is not an error.
                    if (done_show) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else if (cnt == TMO_LAST) begin
                        terr_n  = 1'b1;
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                    if (accept) begin
                        pend_n       = req_entry;
                        pend_valid_n = 1'b1;
                    end
                end

                S_DONE: begin
                    if (pend_valid) begin
                        cur_n        = pend;
                        pend_valid_n = 1'b0;
                        state_n      = S_UPDATE;
                        cnt_n        = '0;
                    end else if (accept) begin
                        cur_n   = req_entry;
                        state_n = S_UPDATE;
                        cnt_n   = '0;
                    end
                end

                default: begin
                    state_n = S_OFF;
                    cnt_n   = '0;
                end
            endcase
        end

        // A fresh request always clears the error, even one set this cycle.
        if (accept) begin
            terr_n = 1'b0;
        end
    end

    // operation is registered and follows the state being entered.
    always_comb begin
        case (state_n)
            S_OFF:    op_n = OP_OFF;
            S_UPDATE: op_n = OP_UPDATE;
            default:  op_n = OP_SHOW;
        endcase
    end

    // Control and visible registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_OFF;
            cnt         <= '0;
            cur         <= '0;
            pend_valid  <= 1'b0;
            timeout_err <= 1'b0;
            operation   <= OP_OFF;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cur         <= cur_n;
            pend_valid  <= pend_valid_n;
            timeout_err <= terr_n;
            operation   <= op_n;
        end
    end

    // Pending payload is only meaningful while pend_valid is set.
    always_ff @(posedge clk) begin
        pend <= pend_n;
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
//   Directed, table-driven bench for lcd_sequencer with UPDATE_CYCLES=4 and
//   TIMEOUT_CYCLES=20. Each table row is applied for 'reps' clock edges and
//   the outputs are compared one time unit after every edge. The asynchronous
//   reset case is a hand-written sequence at the end.
module tb_lcd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        power_on;
    logic        done_show;
    logic [1:0]  operation;
    logic [3:0]  opcode;
    logic [3:0]  addr;
    logic [15:0] value;
    logic        busy;
    logic        timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lcd_sequencer_if bus ();

    lcd_sequencer #(
        .UPDATE_CYCLES (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power_on   (power_on),
        .req        (bus),
        .done_show  (done_show),
        .operation  (operation),
        .opcode     (opcode),
        .addr       (addr),
        .value      (value),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic        pw;
        logic        rv;
        logic [3:0]  rop;
        logic [3:0]  radr;
        logic [15:0] rval;
        logic        ds;
        int          reps;
        logic [1:0]  e_op;
        logic        e_busy;
        logic        e_rdy;
        logic [3:0]  e_opc;
        logic [3:0]  e_adr;
        logic [15:0] e_val;
        logic        e_terr;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input int pw, input int rv, input int rop, input int radr,
                                 input int rval, input int ds, input int reps,
                                 input int e_op, input int e_busy, input int e_rdy,
                                 input int e_opc, input int e_adr, input int e_val,
                                 input int e_terr);
        vec_t v;
        v.pw     = pw[0];
        v.rv     = rv[0];
        v.rop    = rop[3:0];
        v.radr   = radr[3:0];
        v.rval   = rval[15:0];
        v.ds     = ds[0];
        v.reps   = reps;
        v.e_op   = e_op[1:0];
        v.e_busy = e_busy[0];
        v.e_rdy  = e_rdy[0];
        v.e_opc  = e_opc[3:0];
        v.e_adr  = e_adr[3:0];
        v.e_val  = e_val[15:0];
        v.e_terr = e_terr[0];
        vecs.push_back(v);
    endfunction

    task automatic drive(input int pw, input int rv, input int rop, input int radr,
                         input int rval, input int ds);
        power_on       = pw[0];
        bus.req_valid  = rv[0];
        bus.req_opcode = rop[3:0];
        bus.req_addr   = radr[3:0];
        bus.req_value  = rval[15:0];
        done_show      = ds[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int e_op, input int e_busy, input int e_rdy,
                         input int e_opc, input int e_adr, input int e_val, input int e_terr);
        logic [28:0] act;
        logic [28:0] exp;
        act = {operation, busy, bus.req_ready, opcode, addr, value, timeout_err};
        exp = {e_op[1:0], e_busy[0], e_rdy[0], e_opc[3:0], e_adr[3:0], e_val[15:0], e_terr[0]};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got op=%0d busy=%b rdy=%b opc=%h adr=%h val=%h terr=%b, want op=%0d busy=%b rdy=%b opc=%h adr=%h val=%h terr=%b",
                     name, operation, busy, bus.req_ready, opcode, addr, value, timeout_err,
                     exp[28:27], exp[26], exp[25], exp[24:21], exp[20:17], exp[16:1], exp[0]);
        end
    endtask

    initial begin
        // Columns: pw rv rop radr rval ds reps | op busy rdy opc adr val terr
        // 1: power-up with no request, then done_show
        addv(0,0,0,0,16'h0000,0,1,  0,0,1,0,0,16'h0000,0);
        addv(1,0,0,0,16'h0000,0,4,  1,1,1,0,0,16'h0000,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,0,0,16'h0000,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,0,0,16'h0000,0);
        // 2: accept in DONE, full pass, done_show after 7 SHOW cycles
        addv(1,1,1,5,16'h0045,0,1,  1,1,1,1,5,16'h0045,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,1,5,16'h0045,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,1,5,16'h0045,0);
        addv(1,0,0,0,16'h0000,0,6,  2,1,1,1,5,16'h0045,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,1,5,16'h0045,0);
        // 3: X current, A pending during UPDATE, B back-pressured
        addv(1,1,3,1,16'h0001,0,1,  1,1,1,3,1,16'h0001,0);
        addv(1,1,2,2,16'h8003,0,1,  1,1,0,3,1,16'h0001,0);
        addv(1,1,4,3,16'h1234,0,2,  1,1,0,3,1,16'h0001,0);
        addv(1,1,4,3,16'h1234,0,1,  2,1,0,3,1,16'h0001,0);
        addv(1,1,4,3,16'h1234,0,2,  2,1,0,3,1,16'h0001,0);
        addv(1,1,4,3,16'h1234,1,1,  2,0,0,3,1,16'h0001,0);
        addv(1,1,4,3,16'h1234,0,1,  1,1,1,2,2,16'h8003,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,2,2,16'h8003,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,2,2,16'h8003,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,2,2,16'h8003,0);
        addv(1,1,4,3,16'h1234,0,1,  1,1,1,4,3,16'h1234,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,4,3,16'h1234,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,4,3,16'h1234,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,4,3,16'h1234,0);
        // 4a: SHOW timeout after 20 cycles, cleared by next accept (opcode 12)
        addv(1,1,5,6,16'h00FF,0,1,  1,1,1,5,6,16'h00FF,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,5,6,16'h00FF,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,5,6,16'h00FF,0);
        addv(1,0,0,0,16'h0000,0,19, 2,1,1,5,6,16'h00FF,0);
        addv(1,0,0,0,16'h0000,0,1,  2,0,1,5,6,16'h00FF,1);
        addv(1,1,12,7,16'h7FFF,0,1, 1,1,1,12,7,16'h7FFF,0);
        // 4b: done_show on the timeout cycle -> no error
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,12,7,16'h7FFF,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,12,7,16'h7FFF,0);
        addv(1,0,0,0,16'h0000,0,19, 2,1,1,12,7,16'h7FFF,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,12,7,16'h7FFF,0);
        // 4c: accept on the timeout cycle -> clear wins over set
        addv(1,1,7,8,16'h0002,0,1,  1,1,1,7,8,16'h0002,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,7,8,16'h0002,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,7,8,16'h0002,0);
        addv(1,0,0,0,16'h0000,0,19, 2,1,1,7,8,16'h0002,0);
        addv(1,1,1,9,16'h8000,0,1,  2,0,0,7,8,16'h0002,0);
        addv(1,0,0,0,16'h0000,0,1,  1,1,1,1,9,16'h8000,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,1,9,16'h8000,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,1,9,16'h8000,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,1,9,16'h8000,0);
        // 5: power off mid-SHOW with A pending, accept C in OFF, power back on
        addv(1,1,2,10,16'h1111,0,1, 1,1,1,2,10,16'h1111,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,2,10,16'h1111,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,2,10,16'h1111,0);
        addv(1,1,3,11,16'h8005,0,1, 2,1,0,2,10,16'h1111,0);
        addv(0,0,0,0,16'h0000,0,1,  0,0,1,3,11,16'h8005,0);
        addv(0,1,9,12,16'h4321,0,1, 0,0,1,9,12,16'h4321,0);
        addv(1,0,0,0,16'h0000,0,4,  1,1,1,9,12,16'h4321,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,9,12,16'h4321,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,9,12,16'h4321,0);
        // 5b: power off from DONE, then power on with a same-cycle accept
        addv(0,0,0,0,16'h0000,0,1,  0,0,1,9,12,16'h4321,0);
        addv(1,1,13,13,16'hABCD,0,1,1,1,1,13,13,16'hABCD,0);
        addv(1,0,0,0,16'h0000,0,3,  1,1,1,13,13,16'hABCD,0);
        addv(1,0,0,0,16'h0000,0,1,  2,1,1,13,13,16'hABCD,0);
        addv(1,0,0,0,16'h0000,1,1,  2,0,1,13,13,16'hABCD,0);

        rst = 1'b1;
        drive(0,0,0,0,0,0);
        #2;
        check("reset", 0,0,1,0,0,16'h0000,0);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].pw, vecs[i].rv, vecs[i].rop, vecs[i].radr, vecs[i].rval, vecs[i].ds);
                step();
                check($sformatf("vec%0d_rep%0d", i, r), vecs[i].e_op, vecs[i].e_busy, vecs[i].e_rdy,
                      vecs[i].e_opc, vecs[i].e_adr, vecs[i].e_val, vecs[i].e_terr);
            end
        end

        // 6: asynchronous reset mid-UPDATE with a pending entry
        drive(1,1,4,4,16'h0444,0);
        step();
        check("s6_accept_r", 1,1,1,4,4,16'h0444,0);
        drive(1,1,5,5,16'h0555,0);
        step();
        check("s6_pending", 1,1,0,4,4,16'h0444,0);
        drive(1,0,0,0,0,0);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_reset", 0,0,1,0,0,16'h0000,0);
        step();
        check("s6_reset_held", 0,0,1,0,0,16'h0000,0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("s6_update_zero", 1,1,1,0,0,16'h0000,0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("s6_update_%0d", k), 1,1,1,0,0,16'h0000,0);
        end
        step();
        check("s6_show_zero", 2,1,1,0,0,16'h0000,0);
        drive(1,0,0,0,0,1);
        step();
        check("s6_done", 2,0,1,0,0,16'h0000,0);
        drive(1,0,0,0,0,0);
        step();
        check("s6_no_pending", 2,0,1,0,0,16'h0000,0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
